// File: rtl/upc_loop_status_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  upc_mon_pkg : shared defaults and saturating-increment helper for the
//                loop status monitor.  Revision 1.0
// ============================================================================
package upc_mon_pkg;

    localparam int DEF_STATE_W = 8;
    localparam int DEF_CNT_W   = 32;

    // Widths up to 63 bits are supported; callers cast the result back down.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/upc_loop_status_monitor_if.sv
`default_nettype none
// ============================================================================
//  upc_loop_status_monitor_if : read-only tap of the kernel handshake and
//                               loop pipeline control signals.  Revision 1.0
// ============================================================================
interface upc_loop_status_monitor_if #(
    parameter int STATE_W = 8
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] iter_start_state;
    logic [STATE_W-1:0] iter_end_state;
    logic [STATE_W-1:0] quit_state;
    logic               iter_start_block;
    logic               iter_end_block;
    logic               quit_block;
    logic               iter_start_enable;
    logic               iter_end_enable;
    logic               quit_enable;
    logic               loop_start;
    logic               loop_ready;
    logic               loop_done;
    logic               loop_continue;
    logic               quit_at_end;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output cur_state, iter_start_state, iter_end_state, quit_state,
        output iter_start_block, iter_end_block, quit_block,
        output iter_start_enable, iter_end_enable, quit_enable,
        output loop_start, loop_ready, loop_done, loop_continue, quit_at_end
    );

    modport slave (
        input ap_start, ap_ready, ap_done, ap_continue,
        input cur_state, iter_start_state, iter_end_state, quit_state,
        input iter_start_block, iter_end_block, quit_block,
        input iter_start_enable, iter_end_enable, quit_enable,
        input loop_start, loop_ready, loop_done, loop_continue, quit_at_end
    );

endinterface
`default_nettype wire

// File: rtl/upc_loop_status_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  upc_sat_counter : CNT_W saturating counter with freeze, clear, load and
//                    increment (that priority order).  Revision 1.0
// ============================================================================
module upc_sat_counter
    import upc_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire  logic             clock,
    input  wire  logic             reset,
    input  wire  logic             inc,
    input  wire  logic             load,
    input  wire  logic [CNT_W-1:0] load_val,
    input  wire  logic             clear,
    input  wire  logic             freeze,
    output logic       [CNT_W-1:0] count
);

    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = count;
        if (freeze)
            w_next = count;
        else if (clear)
            w_next = '0;
        else if (load)
            w_next = load_val;
        else if (inc)
            w_next = CNT_W'(sat_inc(64'(count), CNT_W));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/upc_loop_status_monitor.sv
`default_nettype none
// ============================================================================
//  upc_loop_status_monitor : passive run/latency/iteration/stall monitor for
//                            one HLS module and one pipelined loop.  Rev 1.0
// ============================================================================
module upc_loop_status_monitor
    import upc_mon_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  wire  logic             clock,
    input  wire  logic             reset,
    input  wire  logic             finish,
    upc_loop_status_monitor_if.slave tap,
    output logic                   mod_busy,
    output logic       [CNT_W-1:0] mod_runs,
    output logic       [CNT_W-1:0] mod_last_lat,
    output logic       [CNT_W-1:0] mod_busy_cycles,
    output logic                   loop_busy,
    output logic       [CNT_W-1:0] loop_invocations,
    output logic       [CNT_W-1:0] loop_last_lat,
    output logic       [CNT_W-1:0] iter_started,
    output logic       [CNT_W-1:0] iter_ended,
    output logic       [CNT_W-1:0] iter_inflight,
    output logic       [CNT_W-1:0] stall_cycles,
    output logic                   frozen
);

    localparam int c_NTRK = 2;

    logic               r_frozen;
    logic [c_NTRK-1:0]  r_busy;
    logic [c_NTRK-1:0]  w_busy_n;
    logic [c_NTRK-1:0]  w_req;
    logic [c_NTRK-1:0]  w_dn;
    logic [c_NTRK-1:0]  w_begin;
    logic [c_NTRK-1:0]  w_fin;
    logic [CNT_W-1:0]   w_lat_q   [c_NTRK];
    logic [CNT_W-1:0]   w_fin_lat [c_NTRK];
    logic [CNT_W-1:0]   w_runs    [c_NTRK];
    logic [CNT_W-1:0]   w_last    [c_NTRK];

    logic [STATE_W-1:0] w_cur;
    logic [STATE_W-1:0] w_iss;
    logic [STATE_W-1:0] w_ies;
    logic [STATE_W-1:0] w_qs;
    logic               w_at_start;
    logic               w_at_end;
    logic               w_at_quit;
    logic               w_is;
    logic               w_ie;
    logic               w_q;
    logic               w_end_evt;
    logic               w_stall;
    logic [CNT_W-1:0]   w_started_n;
    logic [CNT_W-1:0]   w_ended_n;
    logic [CNT_W-1:0]   w_inflight_n;
    logic               w_unused_ready;

    assign w_unused_ready = tap.ap_ready ^ tap.loop_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_frozen <= 1'b0;
        else if (finish)
            r_frozen <= 1'b1;
    end

    // Index 0 tracks the module handshake, index 1 the loop handshake.
    assign w_req = {tap.loop_start, tap.ap_start};
    assign w_dn  = {tap.loop_done && tap.loop_continue, tap.ap_done && tap.ap_continue};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_busy <= '0;
        else if (!r_frozen)
            r_busy <= w_busy_n;
    end

    generate
        for (genvar k = 0; k < c_NTRK; k++) begin : g_trk
            // A completing run may hand over to a new one in the same cycle.
            assign w_begin[k]   = w_req[k] && (!r_busy[k] || w_dn[k]);
            assign w_fin[k]     = w_dn[k] && (r_busy[k] || w_begin[k]);
            assign w_busy_n[k]  = r_busy[k] ? (!w_dn[k] || w_req[k])
                                            : (w_req[k] && !w_dn[k]);
            assign w_fin_lat[k] = r_busy[k] ? CNT_W'(sat_inc(64'(w_lat_q[k]), CNT_W))
                                            : CNT_W'(1);

            upc_sat_counter #(.CNT_W(CNT_W)) u_lat (
                .clock(clock), .reset(reset),
                .inc(r_busy[k]), .load(w_begin[k]), .load_val(CNT_W'(1)),
                .clear(!w_busy_n[k]), .freeze(r_frozen), .count(w_lat_q[k])
            );

            upc_sat_counter #(.CNT_W(CNT_W)) u_runs (
                .clock(clock), .reset(reset),
                .inc(w_fin[k]), .load(1'b0), .load_val('0),
                .clear(1'b0), .freeze(r_frozen), .count(w_runs[k])
            );

            upc_sat_counter #(.CNT_W(CNT_W)) u_last (
                .clock(clock), .reset(reset),
                .inc(1'b0), .load(w_fin[k]), .load_val(w_fin_lat[k]),
                .clear(1'b0), .freeze(r_frozen), .count(w_last[k])
            );
        end
    endgenerate

    upc_sat_counter #(.CNT_W(CNT_W)) u_busy_cycles (
        .clock(clock), .reset(reset),
        .inc(r_busy[0] || w_begin[0]), .load(1'b0), .load_val('0),
        .clear(1'b0), .freeze(r_frozen), .count(mod_busy_cycles)
    );

    assign w_cur = tap.cur_state;
    assign w_iss = tap.iter_start_state;
    assign w_ies = tap.iter_end_state;
    assign w_qs  = tap.quit_state;

    assign w_at_start = (w_cur == w_iss) && tap.iter_start_enable;
    assign w_at_end   = (w_cur == w_ies) && tap.iter_end_enable;
    assign w_at_quit  = (w_cur == w_qs)  && tap.quit_enable;

    assign w_is      = w_at_start && !tap.iter_start_block;
    assign w_ie      = w_at_end   && !tap.iter_end_block;
    assign w_q       = w_at_quit  && !tap.quit_block;
    assign w_end_evt = w_ie || (!tap.quit_at_end && w_q);
    assign w_stall   = r_busy[1] && ((w_at_start && tap.iter_start_block) ||
                                     (w_at_end   && tap.iter_end_block));

    upc_sat_counter #(.CNT_W(CNT_W)) u_started (
        .clock(clock), .reset(reset),
        .inc(w_is), .load(1'b0), .load_val('0),
        .clear(1'b0), .freeze(r_frozen), .count(iter_started)
    );

    upc_sat_counter #(.CNT_W(CNT_W)) u_ended (
        .clock(clock), .reset(reset),
        .inc(w_end_evt), .load(1'b0), .load_val('0),
        .clear(1'b0), .freeze(r_frozen), .count(iter_ended)
    );

    upc_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clock(clock), .reset(reset),
        .inc(w_stall), .load(1'b0), .load_val('0),
        .clear(1'b0), .freeze(r_frozen), .count(stall_cycles)
    );

    // In-flight is derived from the post-edge counts so it stays registered.
    assign w_started_n  = (w_is && !r_frozen)
                          ? CNT_W'(sat_inc(64'(iter_started), CNT_W)) : iter_started;
    assign w_ended_n    = (w_end_evt && !r_frozen)
                          ? CNT_W'(sat_inc(64'(iter_ended), CNT_W)) : iter_ended;
    assign w_inflight_n = (w_started_n > w_ended_n) ? (w_started_n - w_ended_n) : '0;

    upc_sat_counter #(.CNT_W(CNT_W)) u_inflight (
        .clock(clock), .reset(reset),
        .inc(1'b0), .load(1'b1), .load_val(w_inflight_n),
        .clear(1'b0), .freeze(r_frozen), .count(iter_inflight)
    );

    assign mod_busy         = r_busy[0];
    assign mod_runs         = w_runs[0];
    assign mod_last_lat     = w_last[0];
    assign loop_busy        = r_busy[1];
    assign loop_invocations = w_runs[1];
    assign loop_last_lat    = w_last[1];
    assign frozen           = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_upc_loop_status_monitor.sv
`default_nettype none
// ============================================================================
//  tb_upc_loop_status_monitor : directed self-checking bench for the loop
//                               status monitor.  Revision 1.0
// ============================================================================
module tb_upc_loop_status_monitor;

    logic clock = 1'b0;
    logic reset;
    logic finish;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    upc_loop_status_monitor_if #(.STATE_W(8)) tap  ();
    upc_loop_status_monitor_if #(.STATE_W(8)) tap4 ();

    logic        mod_busy, loop_busy, frozen;
    logic [31:0] mod_runs, mod_last_lat, mod_busy_cycles, loop_invocations, loop_last_lat;
    logic [31:0] iter_started, iter_ended, iter_inflight, stall_cycles;

    logic        mod_busy4, loop_busy4, frozen4;
    logic [3:0]  mod_runs4, mod_last_lat4, mod_busy_cycles4, loop_invocations4, loop_last_lat4;
    logic [3:0]  iter_started4, iter_ended4, iter_inflight4, stall_cycles4;

    upc_loop_status_monitor #(.STATE_W(8), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .finish(finish), .tap(tap),
        .mod_busy(mod_busy), .mod_runs(mod_runs), .mod_last_lat(mod_last_lat),
        .mod_busy_cycles(mod_busy_cycles), .loop_busy(loop_busy),
        .loop_invocations(loop_invocations), .loop_last_lat(loop_last_lat),
        .iter_started(iter_started), .iter_ended(iter_ended),
        .iter_inflight(iter_inflight), .stall_cycles(stall_cycles), .frozen(frozen)
    );

    upc_loop_status_monitor #(.STATE_W(8), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .finish(1'b0), .tap(tap4),
        .mod_busy(mod_busy4), .mod_runs(mod_runs4), .mod_last_lat(mod_last_lat4),
        .mod_busy_cycles(mod_busy_cycles4), .loop_busy(loop_busy4),
        .loop_invocations(loop_invocations4), .loop_last_lat(loop_last_lat4),
        .iter_started(iter_started4), .iter_ended(iter_ended4),
        .iter_inflight(iter_inflight4), .stall_cycles(stall_cycles4), .frozen(frozen4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        finish = 1'b0;
        tap.ap_start = 0; tap.ap_ready = 0; tap.ap_done = 0; tap.ap_continue = 1;
        tap.cur_state = 8'h00; tap.iter_start_state = 8'h01;
        tap.iter_end_state = 8'h08; tap.quit_state = 8'h10;
        tap.iter_start_block = 0; tap.iter_end_block = 0; tap.quit_block = 0;
        tap.iter_start_enable = 0; tap.iter_end_enable = 0; tap.quit_enable = 0;
        tap.loop_start = 0; tap.loop_ready = 0; tap.loop_done = 0;
        tap.loop_continue = 1; tap.quit_at_end = 1;
        tap4.ap_start = 0; tap4.ap_ready = 0; tap4.ap_done = 0; tap4.ap_continue = 1;
        tap4.cur_state = 8'h00; tap4.iter_start_state = 8'h01;
        tap4.iter_end_state = 8'h08; tap4.quit_state = 8'h10;
        tap4.iter_start_block = 0; tap4.iter_end_block = 0; tap4.quit_block = 0;
        tap4.iter_start_enable = 0; tap4.iter_end_enable = 0; tap4.quit_enable = 0;
        tap4.loop_start = 0; tap4.loop_ready = 0; tap4.loop_done = 0;
        tap4.loop_continue = 1; tap4.quit_at_end = 1;
        tick(2);
        chk("rst_mod_runs", mod_runs, 0);
        chk("rst_mod_busy", mod_busy, 0);
        chk("rst_iter_started", iter_started, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_iter_started4", iter_started4, 0);
        reset = 1'b0;
        tick(1);

        // Module run: start, 8 busy cycles, done -> latency 10.
        tap.ap_start = 1; tick(1); tap.ap_start = 0;
        chk("run_busy_on", mod_busy, 1);
        tick(8);
        chk("run_busy_cycles_mid", mod_busy_cycles, 9);
        tap.ap_done = 1; tick(1); tap.ap_done = 0;
        chk("run_runs", mod_runs, 1);
        chk("run_last_lat", mod_last_lat, 10);
        chk("run_busy_cycles", mod_busy_cycles, 10);
        chk("run_busy_off", mod_busy, 0);

        // Start and done in the same idle cycle -> latency 1.
        tap.ap_start = 1; tap.ap_done = 1; tick(1); tap.ap_start = 0; tap.ap_done = 0;
        chk("one_runs", mod_runs, 2);
        chk("one_last_lat", mod_last_lat, 1);
        chk("one_busy", mod_busy, 0);
        chk("one_busy_cycles", mod_busy_cycles, 11);

        // Pipelined loop, II=4, 8 iterations.
        tap.loop_start = 1; tick(1); tap.loop_start = 0;
        tap.iter_start_enable = 1; tap.iter_end_enable = 1;
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 4; s++) begin
                tap.cur_state = 8'(1 << s);
                tick(1);
                if (i == 2 && s == 0) chk("loop_inflight_mid", iter_inflight, 1);
            end
        end
        tap.cur_state = 8'h00; tap.loop_done = 1; tick(1); tap.loop_done = 0;
        chk("loop_started", iter_started, 8);
        chk("loop_ended", iter_ended, 8);
        chk("loop_inflight", iter_inflight, 0);
        chk("loop_stall", stall_cycles, 0);
        chk("loop_inv", loop_invocations, 1);
        chk("loop_last_lat", loop_last_lat, 34);

        // Stall: blocked start state ignored while loop idle, counted while busy.
        tap.cur_state = 8'h01; tap.iter_start_block = 1; tick(1);
        chk("stall_idle", stall_cycles, 0);
        tap.loop_start = 1; tick(1); tap.loop_start = 0;
        tick(3);
        chk("stall_cnt", stall_cycles, 3);
        chk("stall_no_start", iter_started, 8);
        tap.iter_start_block = 0; tick(1);
        chk("unblock_started", iter_started, 9);
        chk("unblock_inflight", iter_inflight, 1);

        // Simultaneous start and end.
        tap.iter_end_state = 8'h01; tick(1); tap.iter_end_state = 8'h08;
        chk("simul_started", iter_started, 10);
        chk("simul_ended", iter_ended, 9);
        chk("simul_inflight", iter_inflight, 1);

        // Quit counted as iteration end only when quit_at_end=0.
        tap.cur_state = 8'h10; tap.quit_enable = 1; tap.quit_at_end = 0; tick(1);
        chk("quit_ended", iter_ended, 10);
        chk("quit_inflight", iter_inflight, 0);
        tap.quit_at_end = 1; tick(1);
        chk("quit_at_end_ended", iter_ended, 10);
        tap.quit_state = 8'h08; tap.cur_state = 8'h08; tap.quit_at_end = 0; tick(1);
        chk("quit_dup_ended", iter_ended, 11);
        chk("inflight_clamp", iter_inflight, 0);
        tap.cur_state = 8'h00; tap.quit_enable = 0; tap.quit_at_end = 1;
        tap.iter_start_enable = 0; tap.iter_end_enable = 0;
        tap.loop_done = 1; tick(1); tap.loop_done = 0;
        chk("loop2_inv", loop_invocations, 2);
        chk("loop2_busy", loop_busy, 0);
        chk("loop2_last_lat", loop_last_lat, 10);

        // Back-to-back runs with ap_start held.
        do_reset();
        chk("b2b_rst_runs", mod_runs, 0);
        tap.ap_start = 1; tick(1);
        tick(3);
        tap.ap_done = 1; tick(1); tap.ap_done = 0;
        chk("b2b_lat1", mod_last_lat, 5);
        tick(3);
        chk("b2b_busy", mod_busy, 1);
        tap.ap_done = 1; tick(1); tap.ap_done = 0;
        tick(3);
        tap.ap_done = 1; tick(1); tap.ap_done = 0;
        chk("b2b_runs", mod_runs, 3);
        chk("b2b_last_lat", mod_last_lat, 5);
        chk("b2b_busy_end", mod_busy, 1);
        chk("b2b_busy_cycles", mod_busy_cycles, 13);

        // Asynchronous reset mid-run aborts without recording latency.
        tap.ap_start = 0; tick(2);
        reset = 1'b1; #2;
        chk("abort_busy", mod_busy, 0);
        chk("abort_runs", mod_runs, 0);
        reset = 1'b0;
        tick(1);
        tap.ap_done = 1; tick(1); tap.ap_done = 0;
        chk("abort_no_run", mod_runs, 0);
        chk("abort_no_lat", mod_last_lat, 0);

        // Freeze: events in the finish cycle still count, later ones do not.
        tap.ap_start = 1; tick(1); tap.ap_start = 0;
        tick(2);
        tap.ap_done = 1; finish = 1; tick(1); tap.ap_done = 0; finish = 0;
        chk("frz_frozen", frozen, 1);
        chk("frz_runs", mod_runs, 1);
        chk("frz_lat", mod_last_lat, 4);
        tap.ap_start = 1; tap.ap_done = 1;
        tap.cur_state = 8'h01; tap.iter_start_enable = 1;
        tick(5);
        tap.ap_start = 0; tap.ap_done = 0; tap.iter_start_enable = 0; tap.cur_state = 8'h00;
        chk("frz_hold_runs", mod_runs, 1);
        chk("frz_hold_lat", mod_last_lat, 4);
        chk("frz_hold_busy_cycles", mod_busy_cycles, 4);
        chk("frz_hold_busy", mod_busy, 0);
        chk("frz_hold_started", iter_started, 0);
        do_reset();
        chk("frz_rst_frozen", frozen, 0);
        chk("frz_rst_runs", mod_runs, 0);
        chk("frz_rst_busy_cycles", mod_busy_cycles, 0);

        // Saturation on the 4-bit instance.
        tap4.cur_state = 8'h01; tap4.iter_start_enable = 1;
        tick(15);
        chk("sat_started_15", iter_started4, 15);
        tick(1);
        chk("sat_started_hold", iter_started4, 15);
        chk("sat_inflight", iter_inflight4, 15);
        chk("sat_ended", iter_ended4, 0);
        tap4.iter_start_enable = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
